pipe_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. It generalises the single-bit full adder to WIDTH bits, with carry propagation split across STAGES register stages. A valid/ready handshake on input and output gives one result per cycle at full throughput and lossless stalling under backpressure. It is the arithmetic primitive for the datapath blocks that follow in this module set.

---
 rtl/pipe_addsub.sv | 118 +++++++++++
 tb/tb_pipe_addsub.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES
// carry-propagating chunks, with a valid/ready handshake at both ends.
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = WIDTH / STAGES;

    // Per-stage registers; a_r/b_r keep full width, only unconsumed upper chunks matter.
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  sum_r [STAGES];
    logic [STAGES-1:0] c_r;
    logic [STAGES-1:0] v_r;
    logic              ovf_r;

    logic [WIDTH-1:0]  up_a_s [STAGES];
    logic [WIDTH-1:0]  up_b_s [STAGES];
    logic [WIDTH-1:0]  up_sum_s [STAGES];
    logic [STAGES-1:0] up_c_s;
    logic [STAGES-1:0] up_v_s;
    logic [WIDTH-1:0]  nx_sum_s [STAGES];
    logic [STAGES-1:0] nx_c_s;
    logic [STAGES-1:0] rdy_s;
    logic              nx_ovf_s;

    // Upstream payload for each stage and the chunk add it performs.
    always_comb begin
        logic [CHUNK:0] chunk_v;
        up_a_s[0]   = a;
        up_b_s[0]   = sub ? ~b : b;
        up_sum_s[0] = '0;
        up_c_s      = '0;
        up_v_s      = '0;
        up_c_s[0]   = sub ? ~cin : cin;
        up_v_s[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            up_a_s[k]   = a_r[k-1];
            up_b_s[k]   = b_r[k-1];
            up_sum_s[k] = sum_r[k-1];
            up_c_s[k]   = c_r[k-1];
            up_v_s[k]   = v_r[k-1];
        end
        nx_c_s = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk_v = {1'b0, up_a_s[k][k*CHUNK +: CHUNK]}
                    + {1'b0, up_b_s[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, up_c_s[k]};
            nx_sum_s[k] = up_sum_s[k];
            nx_sum_s[k][k*CHUNK +: CHUNK] = chunk_v[CHUNK-1:0];
            nx_c_s[k] = chunk_v[CHUNK];
        end
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        nx_ovf_s = nx_c_s[STAGES-1] ^ up_a_s[STAGES-1][WIDTH-1]
                 ^ up_b_s[STAGES-1][WIDTH-1] ^ nx_sum_s[STAGES-1][WIDTH-1];
    end

    // Combinational ready chain from the output back to the input.
    always_comb begin
        rdy_s = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (k == STAGES - 1) begin
                rdy_s[k] = out_ready | ~v_r[k];
            end else begin
                rdy_s[k] = ~v_r[k] | rdy_s[k+1];
            end
        end
    end

    // Stage registers: load when ready, otherwise hold; payload only moves with valid data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                sum_r[k] <= '0;
            end
            c_r   <= '0;
            v_r   <= '0;
            ovf_r <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy_s[k]) begin
                    v_r[k] <= up_v_s[k];
                    if (up_v_s[k]) begin
                        a_r[k]   <= up_a_s[k];
                        b_r[k]   <= up_b_s[k];
                        sum_r[k] <= nx_sum_s[k];
                        c_r[k]   <= nx_c_s[k];
                    end
                end
            end
            if (rdy_s[STAGES-1] && up_v_s[STAGES-1]) begin
                ovf_r <= nx_ovf_s;
            end
        end
    end

    assign in_ready  = rdy_s[0];
    assign out_valid = v_r[STAGES-1];
    assign s         = sum_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign ovf       = ovf_r;
endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed table, random streaming with
// backpressure and reset, checked against an arithmetic reference model.
module tb_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, s;
    logic        t_valid, t_cin, t_sub;
    logic [15:0] t_a, t_b;
    logic        r1_ready, r1_valid, r1_cout, r1_ovf;
    logic        r16_ready, r16_valid, r16_cout, r16_ovf;
    logic [15:0] r1_s, r16_s;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [17:0] exp_q[$];
    int          out_cyc[$];
    logic        prev_stall = 1'b0;
    logic [17:0] held;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] es;
        logic        ec, eo;
    } vec_t;
    vec_t tbl[8];

    pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf));
    pipe_addsub #(.WIDTH(16), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(t_valid), .in_ready(r1_ready),
        .a(t_a), .b(t_b), .cin(t_cin), .sub(t_sub), .out_valid(r1_valid),
        .out_ready(1'b1), .s(r1_s), .cout(r1_cout), .ovf(r1_ovf));
    pipe_addsub #(.WIDTH(16), .STAGES(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(t_valid), .in_ready(r16_ready),
        .a(t_a), .b(t_b), .cin(t_cin), .sub(t_sub), .out_valid(r16_valid),
        .out_ready(1'b1), .s(r16_s), .cout(r16_cout), .ovf(r16_ovf));

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, s}.
    function automatic logic [17:0] ref_calc(input logic [15:0] x, input logic [15:0] y,
                                             input logic ci, input logic sb);
        int          su, ss;
        logic [31:0] t;
        logic        co, ov;
        if (!sb) begin
            su = int'(x) + int'(y) + int'(ci);
            ss = int'($signed(x)) + int'($signed(y)) + int'(ci);
            co = (su >= 65536);
        end else begin
            su = int'(x) - int'(y) - int'(ci);
            ss = int'($signed(x)) - int'($signed(y)) - int'(ci);
            co = (su >= 0);
        end
        ov = (ss > 32767) || (ss < -32768);
        t  = su;
        return {ov, co, t[15:0]};
    endfunction

    // Scoreboard and stall-stability monitor for the 4-stage instance.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_payload", 32'({ovf, cout, s}), 32'(held));
            end
            prev_stall = out_valid && !out_ready;
            held = {ovf, cout, s};
            if (in_valid && in_ready) exp_q.push_back(ref_calc(a, b, cin, sub));
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc + 1);
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'({ovf, cout, s}), 32'hDEAD);
                end else begin
                    check("stream_result", 32'({ovf, cout, s}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic rand_in();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    initial begin
        int   lat, lat1, lat16, n0;
        logic took;
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[6] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        t_valid = 1'b0; t_a = '0; t_b = '0; t_cin = 1'b0; t_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'({ovf, cout, s}), 32'd0);
        check("rst_in_ready", 32'({in_ready, r1_ready, r16_ready}), 32'h7);
        rst = 1'b0;

        // Directed table on STAGES=4, STAGES=1 and STAGES=16 with latency checks.
        for (int i = 0; i < 8; i++) begin
            a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub; in_valid = 1'b1;
            t_a = tbl[i].a; t_b = tbl[i].b; t_cin = tbl[i].cin; t_sub = tbl[i].sub; t_valid = 1'b1;
            lat = 0; lat1 = 0; lat16 = 0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk);
                #1;
                if (c == 1) begin
                    in_valid = 1'b0;
                    t_valid  = 1'b0;
                end
                if (out_valid && lat == 0) begin
                    lat = c;
                    check("tbl_s4", 32'({ovf, cout, s}), 32'({tbl[i].eo, tbl[i].ec, tbl[i].es}));
                end
                if (r1_valid && lat1 == 0) begin
                    lat1 = c;
                    check("tbl_s1", 32'({r1_ovf, r1_cout, r1_s}), 32'({tbl[i].eo, tbl[i].ec, tbl[i].es}));
                end
                if (r16_valid && lat16 == 0) begin
                    lat16 = c;
                    check("tbl_s16", 32'({r16_ovf, r16_cout, r16_s}), 32'({tbl[i].eo, tbl[i].ec, tbl[i].es}));
                end
            end
            check("lat_s4", 32'(lat), 32'd4);
            check("lat_s1", 32'(lat1), 32'd1);
            check("lat_s16", 32'(lat16), 32'd16);
        end

        // Eight back-to-back random operations: consecutive, in-order outputs.
        out_cyc.delete();
        n0 = cyc;
        for (int i = 0; i < 8; i++) begin
            rand_in();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("burst_count", 32'(out_cyc.size()), 32'd8);
        for (int i = 0; i < 8 && i < out_cyc.size(); i++)
            check("burst_timing", 32'(out_cyc[i]), 32'(n0 + 5 + i));

        // Continuous stream with a 6-cycle output stall.
        rand_in();
        in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (c == 14) begin
                check("full_in_ready", 32'(in_ready), 32'd0);
                check("full_occupancy", 32'(exp_q.size()), 32'd4);
            end
            @(posedge clk);
            #1;
            out_ready = !(c >= 9 && c < 15);
            if (took) rand_in();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Reset with three results in flight: nothing stale may emerge.
        for (int i = 0; i < 3; i++) begin
            rand_in();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        check("no_stale", 32'(lat), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
